alu_writeback: RTL and testbench



---
 rtl/alu_writeback.sv | 107 ++++++++++
 tb/tb_alu_writeback.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result sink: FLAGS merge register plus 2-entry register-write skid buffer.
// Optional macro ALU_WB_FLAGS_FWD_EN: drive flags_fwd combinationally with the flags value being committed this cycle.
module alu_writeback #(
    parameter logic [15:0] FLAGS_RESET = 16'hF002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_result,
    input  logic [15:0] in_flags,
    input  logic [15:0] in_flags_mask,
    input  logic        in_wr_en,
    input  logic [2:0]  in_dest_reg,
    input  logic        in_is_8_bit,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_dest_reg,
    output logic        out_is_8_bit,
    output logic [15:0] flags,
    output logic [15:0] flags_fwd
);

    // Bit 1 and bits 15:12 always read 1; bits 3 and 5 always read 0.
    localparam logic [15:0] FIXED_ONES  = 16'hF002;
    localparam logic [15:0] FIXED_ZEROS = 16'h0028;
    localparam logic [15:0] FLAGS_INIT  = (FLAGS_RESET | FIXED_ONES) & ~FIXED_ZEROS;

    logic [15:0] flags_q, flags_d, flags_merged;
    logic [19:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic        accept, push, pop;
    logic [19:0] new_entry;

    assign accept       = in_valid & in_ready_q & ~flush;
    assign push         = accept & in_wr_en;
    assign pop          = out_valid & out_ready;
    assign new_entry    = {in_result, in_dest_reg, in_is_8_bit};
    assign flags_merged = (((flags_q & ~in_flags_mask) | (in_flags & in_flags_mask))
                           | FIXED_ONES) & ~FIXED_ZEROS;
    assign flags_d      = accept ? flags_merged : flags_q;

    // Entry 0 is always the head; entry 1 shifts down on pop.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = new_entry;
                    else                 ent1_d = new_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = new_entry;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = new_entry;
                    end
                end
                default: ;
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q    <= FLAGS_INIT;
            ent0_q     <= '0;
            ent1_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            flags_q    <= flags_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (count_q != 2'd0);
    assign out_result   = ent0_q[19:4];
    assign out_dest_reg = ent0_q[3:1];
    assign out_is_8_bit = ent0_q[0];
    assign flags        = flags_q;

`ifdef ALU_WB_FLAGS_FWD_EN
    assign flags_fwd = flags_d;
`else
    assign flags_fwd = flags_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed and randomized checks of alu_writeback against a queue-based model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [15:0] in_flags;
    logic [15:0] in_flags_mask;
    logic        in_wr_en;
    logic [2:0]  in_dest_reg;
    logic        in_is_8_bit;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_dest_reg;
    logic        out_is_8_bit;
    logic [15:0] flags;
    logic [15:0] flags_fwd;

    alu_writeback #(.FLAGS_RESET(16'hF002)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_flags_mask(in_flags_mask), .in_wr_en(in_wr_en),
        .in_dest_reg(in_dest_reg), .in_is_8_bit(in_is_8_bit), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest_reg(out_dest_reg), .out_is_8_bit(out_is_8_bit),
        .flags(flags), .flags_fwd(flags_fwd)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  dst;
        logic        b8;
    } wr_t;

    wr_t         q[$];
    logic [15:0] mflags;

    function automatic logic [15:0] fixf(input logic [15:0] v);
        logic [15:0] r;
        r        = v;
        r[1]     = 1'b1;
        r[3]     = 1'b0;
        r[5]     = 1'b0;
        r[15:12] = 4'hF;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_state();
        chk("flags", {16'h0, flags}, {16'h0, mflags});
        chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
        chk("in_ready", {31'h0, in_ready}, {31'h0, q.size() < 2});
        if (q.size() != 0) begin
            chk("out_result", {16'h0, out_result}, {16'h0, q[0].res});
            chk("out_dest_reg", {29'h0, out_dest_reg}, {29'h0, q[0].dst});
            chk("out_is_8_bit", {31'h0, out_is_8_bit}, {31'h0, q[0].b8});
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] fl,
                         input logic [15:0] mk, input logic wr, input logic [2:0] dst,
                         input logic b8, input logic fls, input logic ordy);
        in_valid = v; in_result = res; in_flags = fl; in_flags_mask = mk;
        in_wr_en = wr; in_dest_reg = dst; in_is_8_bit = b8; flush = fls; out_ready = ordy;
    endtask

    // Called at posedge+1 with inputs already driven; advances one clock and updates the model.
    task automatic step();
        bit          acc, pp;
        logic [15:0] nf;
        acc = in_valid && (q.size() < 2) && !flush;
        pp  = (q.size() != 0) && out_ready;
        nf  = acc ? fixf((mflags & ~in_flags_mask) | (in_flags & in_flags_mask)) : mflags;
        #3;
`ifdef ALU_WB_FLAGS_FWD_EN
        chk("flags_fwd_pre", {16'h0, flags_fwd}, {16'h0, nf});
`else
        chk("flags_fwd_pre", {16'h0, flags_fwd}, {16'h0, mflags});
`endif
        @(posedge clk); #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc && in_wr_en) q.push_back('{res: in_result, dst: in_dest_reg, b8: in_is_8_bit});
        end
        mflags = nf;
        check_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 0);
        mflags = 16'hF002;
        #1;
        chk("rst_flags", {16'h0, flags}, 32'h0000F002);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_fields", {12'h0, out_result, out_dest_reg, out_is_8_bit}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Flags merge with fixed bits from reset.
        drive(1, 16'h0, 16'h08D5, 16'h08D5, 0, 3'd0, 0, 0, 0);
        step();
        chk("merge_08D5", {16'h0, flags}, 32'h0000F8D7);

        // Three writes against a stalled consumer.
        drive(1, 16'h1111, 16'h0, 16'h0, 1, 3'd1, 0, 0, 0); step();
        chk("r1_visible", {16'h0, out_result}, 32'h00001111);
        drive(1, 16'h2222, 16'h0, 16'h0, 1, 3'd2, 1, 0, 0); step();
        chk("full_ready_low", {31'h0, in_ready}, 32'h0);
        drive(1, 16'h3333, 16'h0, 16'h0, 1, 3'd3, 0, 0, 0); step();
        chk("stall_head_hold", {16'h0, out_result}, 32'h00001111);
        out_ready = 1'b1; step();
        chk("pop1_head", {16'h0, out_result}, 32'h00002222);
        chk("ready_after_pop", {31'h0, in_ready}, 32'h1);
        step();
        chk("pop2_head", {16'h0, out_result}, 32'h00003333);
        in_valid = 1'b0; step();
        chk("drained", {31'h0, out_valid}, 32'h0);

        // Flags-only accepts: clear then set CF.
        drive(1, 16'hABCD, 16'h0000, 16'h0001, 0, 3'd4, 0, 0, 0); step();
        chk("cf_clear", {16'h0, flags}, 32'h0000F8D6);
        drive(1, 16'hABCD, 16'h0001, 16'h0001, 0, 3'd4, 0, 0, 0); step();
        chk("cf_set", {16'h0, flags}, 32'h0000F8D7);
        chk("flags_only_no_push", {31'h0, out_valid}, 32'h0);

        // Flush with two buffered entries and a concurrent input.
        drive(1, 16'h4444, 16'h0, 16'h0, 1, 3'd4, 0, 0, 0); step();
        drive(1, 16'h5555, 16'h0, 16'h0, 1, 3'd5, 0, 0, 0); step();
        drive(1, 16'h6666, 16'h0000, 16'hFFFF, 1, 3'd6, 0, 1, 0); step();
        chk("flush2_empty", {31'h0, out_valid}, 32'h0);
        chk("flush2_flags", {16'h0, flags}, 32'h0000F8D7);
        chk("flush2_ready", {31'h0, in_ready}, 32'h1);

        // Flush with one entry while ready: the accept and its flags commit are suppressed.
        drive(1, 16'h7777, 16'h0, 16'h0, 1, 3'd7, 1, 0, 0); step();
        drive(1, 16'h8888, 16'h0000, 16'hFFFF, 1, 3'd0, 0, 1, 1); step();
        chk("flush1_empty", {31'h0, out_valid}, 32'h0);
        chk("flush1_flags", {16'h0, flags}, 32'h0000F8D7);

        // Forwarding of bit 6.
        drive(1, 16'h0, 16'h0000, 16'h0040, 0, 3'd0, 0, 0, 0); step();
        chk("bit6_clear", {16'h0, flags}, 32'h0000F897);
        drive(1, 16'h0, 16'h0040, 16'h0040, 0, 3'd0, 0, 0, 0);
        #3;
`ifdef ALU_WB_FLAGS_FWD_EN
        chk("fwd_bit6_same_cycle", {31'h0, flags_fwd[6]}, 32'h1);
`else
        chk("fwd_bit6_same_cycle", {31'h0, flags_fwd[6]}, 32'h0);
`endif
        @(posedge clk); #1;
        mflags = 16'hF8D7;
        chk("fwd_bit6_next", {31'h0, flags_fwd[6]}, 32'h1);
        check_state();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
            step();
        end

        // Asynchronous reset mid-operation.
        drive(1, 16'h9999, 16'h0, 16'h0, 1, 3'd1, 0, 0, 0); step();
        drive(1, 16'hAAAA, 16'h0FFF, 16'hFFFF, 1, 3'd2, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        mflags = 16'hF002;
        chk("async_rst_flags", {16'h0, flags}, 32'h0000F002);
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_state();
        drive(0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 1); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
